// File: rtl/reg_file_wb_arbiter.sv
// Round-robin arbiter for the reg_file write port, plus a pending-write scoreboard for issue.
// Latency: a grant registers the write one cycle later; busy clears on the commit edge.
// Backpressure: none downstream; exactly one requester is granted whenever any is valid.
module reg_file_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic                      rsv_en_i,
    input  logic [ADDR_W-1:0]         rsv_addr_i,
    input  logic [ADDR_W-1:0]         chk1_addr_i,
    input  logic [ADDR_W-1:0]         chk2_addr_i,
    output logic                      chk1_busy_o,
    output logic                      chk2_busy_o,
    output logic                      rg_write_en_o,
    output logic [ADDR_W-1:0]         rg_des_addr_o,
    output logic [DATA_W-1:0]         rg_des_data_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NREG  = 1 << ADDR_W;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] des_addr_q, des_addr_d;
    logic [DATA_W-1:0] des_data_q, des_data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    logic              hi_any, lo_any, xfer;
    logic [PTR_W-1:0]  hi_idx, lo_idx, grant_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

    // Lowest valid index at/after ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                lo_any = 1'b1;
                lo_idx = PTR_W'(i);
                if (PTR_W'(i) >= ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
        grant_idx = hi_any ? hi_idx : lo_idx;
        xfer      = lo_any;
    end

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        des_addr_d = des_addr_q;
        des_data_d = des_data_q;
        if (xfer) begin
            ptr_d      = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            des_addr_d = addr_arr[grant_idx];
            des_data_d = data_arr[grant_idx];
            wr_en_d    = (addr_arr[grant_idx] != '0);
        end
    end

    // Set is applied after clear so a fresh reservation survives a commit to the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[des_addr_q] = 1'b0;
        end
        if (rsv_en_i && (rsv_addr_i != '0)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            des_addr_q <= '0;
            des_data_q <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            des_addr_q <= des_addr_d;
            des_data_q <= des_data_d;
            busy_q     <= busy_d;
        end
    end

    assign chk1_busy_o   = busy_q[chk1_addr_i];
    assign chk2_busy_o   = busy_q[chk2_addr_i];
    assign rg_write_en_o = wr_en_q;
    assign rg_des_addr_o = des_addr_q;
    assign rg_des_data_o = des_data_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Randomized and directed bench for reg_file_wb_arbiter against a queue/array-level model.
module tb_reg_file_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr, chk1_addr, chk2_addr;
    logic          chk1_busy, chk2_busy, rg_we;
    logic [AW-1:0] rg_addr;
    logic [DW-1:0] rg_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: pointer, pending bits, write in flight, and register contents.
    int          m_ptr;
    bit          m_busy [32];
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_rf   [32];
    logic [31:0] rf_dut [32];
    int          last_g;

    reg_file_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .rsv_en_i      (rsv_en),
        .rsv_addr_i    (rsv_addr),
        .chk1_addr_i   (chk1_addr),
        .chk2_addr_i   (chk2_addr),
        .chk1_busy_o   (chk1_busy),
        .chk2_busy_o   (chk2_busy),
        .rg_write_en_o (rg_we),
        .rg_des_addr_o (rg_addr),
        .rg_des_data_o (rg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int g;
        g = model_grant();
        check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("rg_write_en", rg_we, m_wen);
        check("rg_des_addr", rg_addr, m_waddr);
        check("rg_des_data", rg_data, m_wdata);
        check("chk1_busy", chk1_busy, m_busy[chk1_addr]);
        check("chk2_busy", chk2_busy, m_busy[chk2_addr]);
        check("rf_read", rf_dut[chk1_addr], m_rf[chk1_addr]);
    endtask

    task automatic m_reset();
        m_ptr = 0;
        m_wen = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    // One clock: compare, advance the model by the rules, and act as the reg_file on the DUT outputs.
    task automatic cycle();
        int g;
        logic s_we;
        logic [4:0] s_a, ga;
        logic [31:0] s_d, gd;
        #1;
        compare_all();
        g = model_grant();
        last_g = g;
        s_we = rg_we;
        s_a = rg_addr;
        s_d = rg_data;
        @(posedge clk);
        if (m_wen) begin
            m_rf[m_waddr] = m_wdata;
            m_busy[m_waddr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        if (g >= 0) begin
            ga = req_addr[g*AW +: AW];
            gd = req_data[g*DW +: DW];
            m_ptr = (g + 1) % N;
            m_wen = (ga != 0);
            m_waddr = ga;
            m_wdata = gd;
        end else begin
            m_wen = 1'b0;
        end
        if (s_we && rst_n) rf_dut[s_a] = s_d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i] = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        rsv_en = 1'b0;
        rsv_addr = '0;
        chk1_addr = '0;
        chk2_addr = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = '0;
            rf_dut[i] = '0;
        end
        clear_inputs();
        rst_n = 1'b0;
        last_g = -1;
        @(negedge clk);

        // Reset while a write sits in the output stage: it must be dropped.
        do_reset();
        chk1_addr = 5'd5;
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        req_valid = '0;
        #1;
        check("midrst_wen_before", rg_we, 1'b1);
        check("midrst_addr_before", rg_addr, 5'd5);
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("midrst_wen", rg_we, 1'b0);
        check("midrst_addr", rg_addr, 5'd0);
        check("midrst_data", rg_data, 32'd0);
        check("midrst_busy", chk1_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_x5", rf_dut[5], 32'd0);

        // Single reserved write to x1.
        do_reset();
        clear_inputs();
        rsv_en = 1'b1;
        rsv_addr = 5'd1;
        chk1_addr = 5'd1;
        cycle();
        rsv_en = 1'b0;
        set_req(1, 1'b1, 5'd1, 32'hDEADBEEF);
        #1;
        check("sw_ready", req_ready, 3'b010);
        check("sw_busy_pending", chk1_busy, 1'b1);
        cycle();
        req_valid = '0;
        #1;
        check("sw_wen", rg_we, 1'b1);
        check("sw_addr", rg_addr, 5'd1);
        check("sw_busy_inflight", chk1_busy, 1'b1);
        cycle();
        #1;
        check("sw_busy_cleared", chk1_busy, 1'b0);
        check("sw_rf", rf_dut[1], 32'hDEADBEEF);

        // Round-robin fairness, then two requesters alternating.
        do_reset();
        clear_inputs();
        set_req(0, 1'b1, 5'd1, 32'h1111_0000);
        set_req(1, 1'b1, 5'd2, 32'h2222_0000);
        set_req(2, 1'b1, 5'd3, 32'h3333_0000);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_grant", req_ready, 64'd1 << (k % 3));
            if (k > 0) check("rr_wen", rg_we, 1'b1);
            cycle();
        end
        req_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr2_grant", req_ready, (k % 2 == 0) ? 3'b010 : 3'b100);
            cycle();
        end

        // Pointer wrap from the last requester back to zero.
        do_reset();
        clear_inputs();
        set_req(2, 1'b1, 5'd4, 32'hA5A5_0002);
        #1;
        check("wrap_g2", req_ready, 3'b100);
        cycle();
        req_valid = '0;
        set_req(0, 1'b1, 5'd6, 32'hA5A5_0000);
        #1;
        check("wrap_g0", req_ready, 3'b001);
        cycle();
        req_valid = '0;

        // x0 requests are consumed without writing; x0 is never busy.
        do_reset();
        clear_inputs();
        set_req(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("x0_ready", req_ready, 3'b001);
        cycle();
        req_valid = '0;
        #1;
        check("x0_wen", rg_we, 1'b0);
        rsv_en = 1'b1;
        rsv_addr = 5'd0;
        chk1_addr = 5'd0;
        cycle();
        rsv_en = 1'b0;
        #1;
        check("x0_busy", chk1_busy, 1'b0);

        // Reserve on the same edge that commits x7: busy must stay set.
        do_reset();
        clear_inputs();
        rsv_en = 1'b1;
        rsv_addr = 5'd7;
        chk1_addr = 5'd7;
        cycle();
        rsv_en = 1'b0;
        set_req(0, 1'b1, 5'd7, 32'h1234_5678);
        cycle();
        req_valid = '0;
        rsv_en = 1'b1;
        rsv_addr = 5'd7;
        #1;
        check("coll_wen", rg_we, 1'b1);
        cycle();
        rsv_en = 1'b0;
        #1;
        check("coll_busy", chk1_busy, 1'b1);
        check("coll_rf", rf_dut[7], 32'h1234_5678);

        // Random traffic; a request is held until it is granted.
        do_reset();
        clear_inputs();
        last_g = -1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    set_req(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
                end
            end
            rsv_en = ($urandom_range(0, 3) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            chk1_addr = 5'($urandom_range(0, 7));
            chk2_addr = 5'($urandom_range(0, 7));
            if (c == 400) begin
                do_reset();
                last_g = -1;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
